shift_add_multiplier: RTL and testbench
=======================================

// Module: shift_add_multiplier
// PURPOSE
//   Sequential unsigned fixed-point multiplier. Inverse-operation companion to the divider.
//   Uses the same start/busy/valid handshake, so the same control sequencer can drive
//   either unit. Radix-2 shift-add: one multiplier bit per cycle.
//   Output is a WIDTH-bit product in the operand Q-format, with an overflow flag.
// PARAMETERS
//   WIDTH  10  operand and result width (bits)
//   FRAC   0   fractional bits in a_in, b_in and p_out (0 <= FRAC < WIDTH)
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   sclr_n  in   1      synchronous active-low reset: sampled on clk edge, low = clear
//   start   in   1      request; sampled only when not busy
//   a_in    in   WIDTH  multiplicand, captured on accepted start
//   b_in    in   WIDTH  multiplier, captured on accepted start
//   busy    out  1      high while a multiplication is in progress
//   valid   out  1      one-cycle pulse: p_out/ovf hold a new result
//   ovf     out  1      result did not fit in WIDTH bits (held with p_out)
//   p_out   out  WIDTH  product in Q(WIDTH-FRAC).FRAC, held until next result
// BEHAVIOUR
//   Reset (sclr_n=0 at an edge):
//     - state=IDLE; busy=0, valid=0, ovf=0, p_out=0.
//     - Internal acc, mplr, mcand and cnt are cleared.
//     - Reset wins over every other input and aborts any operation in flight.
//     - No valid pulse for the aborted operation.
//   FSM states: IDLE -> RUN -> DONE -> (IDLE | RUN)
//     IDLE:
//       - busy=0, valid=0.
//       - start=1 at an edge: mcand<=a_in, mplr<=b_in, acc<=0, cnt<=0; go RUN.
//     RUN (WIDTH cycles):
//       - busy=1.
//       - Each edge: {acc,mplr} <= ({acc + (mplr[0] ? mcand : 0)}, mplr) >> 1.
//       - acc is WIDTH+1 bits, so the carry is kept.
//       - cnt++; after the edge where cnt==WIDTH-1, go DONE.
//     DONE (1 cycle):
//       - valid=1, busy=0; p_out/ovf already updated on entry.
//       - start=1: accepted exactly as in IDLE (back-to-back ops, no idle gap).
//       - Otherwise go IDLE.
//   Handshake:
//     - start is ignored while busy=1; it is not queued.
//     - a_in/b_in need only be stable on the accepting edge.
//     - start held high continuously gives back-to-back ops, each WIDTH+1 cycles apart.
//   Latency:
//     - start accepted at edge E0; valid=1 during the cycle after edge E0+WIDTH.
//     - busy is high for exactly WIDTH cycles.
//   Arithmetic: full product P = {acc[WIDTH-1:0], mplr}, 2*WIDTH bits.
//     - p_out = P[FRAC+WIDTH-1:FRAC]; low FRAC bits are truncated toward zero, no rounding.
//     - ovf = |P[2*WIDTH-1:FRAC+WIDTH]. On overflow, p_out still carries the truncated bits.
//     - p_out and ovf are registered on the RUN->DONE edge.
//     - They hold through IDLE and the next RUN; change only at the next DONE or reset.
//   Zero operand: no early exit; still WIDTH cycles, result 0, ovf=0.
// STRUCTURE
//   Shared package mult_pkg:
//     - FSM state localparams: IDLE, RUN, DONE (2-bit encoding).
//     - Default WIDTH/FRAC constants.
//     - Counter width function: $clog2(WIDTH).
//   One sub-module, shift_add_datapath:
//     - Holds acc/mplr/mcand registers, adder, shifter and output registers.
//     - Controls in: ld, shen, ld_out. Status out: cnt_done.
//   FSM and counter-decode glue stay in the top level.
// TESTING (WIDTH=10, FRAC=0 unless noted)
//   1. Reset mid-RUN:
//      - start a=7,b=9; drop sclr_n at cycle 4.
//      - Expect: all outputs 0 next cycle, no valid pulse, next op works normally.
//   2. Basic:
//      - a=25, b=20.
//      - Expect: busy high exactly 10 cycles; valid one cycle at E0+11; p_out=500, ovf=0.
//   3. Overflow:
//      - a=40, b=30 (P=1200).
//      - Expect: ovf=1, p_out=1200 mod 1024=176. Also a=b=1023 -> ovf=1, p_out=1.
//   4. Handshake:
//      - Pulse start during RUN with a=3, b=3: ignored; first result unchanged.
//      - start held high with a=3,b=5 then a=6,b=7 at the DONE cycle.
//      - Expect: valid pulses 11 cycles apart with p_out 15 then 42; p_out stable between.
//   5. Fixed point (FRAC=4):
//      - a=0x028 (2.5), b=0x018 (1.5).
//      - Expect: p_out=0x03C (3.75), ovf=0.
//      - a=0x3FF, b=0x020 -> ovf=1.
//   6. Zero/identity:
//      - a=0,b=1023 -> p_out=0, ovf=0.
//      - a=1,b=513 -> p_out=513.
//      - Both take full latency.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_t   : sequencer states IDLE / RUN / DONE (2-bit)
//   DEF_WIDTH : default operand/result width
//   DEF_FRAC  : default fractional bit count
//   cnt_w()   : width of the per-bit cycle counter
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 10;
   localparam int unsigned DEF_FRAC  = 0;

   // At least one bit, so that WIDTH=1 still gets a legal counter.
   function automatic int unsigned cnt_w(input int unsigned width);
      return ($clog2(width) > 0) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Radix-2 shift-add datapath: accumulator, multiplier/multiplicand registers,
// bit counter and registered result.
//   clk, sclr_n        : clock, synchronous active-low clear
//   ld                 : capture a_in/b_in, clear acc and counter
//   shen               : perform one add-and-shift step, count it
//   ld_out             : register product/overflow from this step's result
//   a_in, b_in         : multiplicand, multiplier
//   cnt_done           : current step is the last (cnt == WIDTH-1)
//   p_out, ovf         : registered product slice and overflow flag
module shift_add_datapath
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned FRAC  = DEF_FRAC,
   parameter int unsigned CW    = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             sclr_n,
   input  logic             ld,
   input  logic             shen,
   input  logic             ld_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             cnt_done,
   output logic [WIDTH-1:0] p_out,
   output logic             ovf
);

   logic [WIDTH:0]     r_acc;
   logic [WIDTH-1:0]   r_mplr;
   logic [WIDTH-1:0]   r_mcand;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_p;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_acc_nxt;
   logic [WIDTH-1:0]   w_mplr_nxt;
   logic [2*WIDTH-1:0] w_prod;

   // The result registers are loaded from the post-shift values of the
   // final step, so the product is ready on the same edge that enters DONE.
   always_comb begin
      w_addend   = r_mplr[0] ? r_mcand : '0;
      w_sum      = r_acc + {1'b0, w_addend};
      w_acc_nxt  = {1'b0, w_sum[WIDTH:1]};
      w_mplr_nxt = {w_sum[0], r_mplr[WIDTH-1:1]};
      w_prod     = {w_acc_nxt[WIDTH-1:0], w_mplr_nxt};
   end

   assign cnt_done = (r_cnt == CW'(WIDTH-1));

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         r_acc   <= '0;
         r_mplr  <= '0;
         r_mcand <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (ld) begin
            r_mcand <= a_in;
            r_mplr  <= b_in;
            r_acc   <= '0;
            r_cnt   <= '0;
         end else if (shen) begin
            r_acc  <= w_acc_nxt;
            r_mplr <= w_mplr_nxt;
            r_cnt  <= r_cnt + 1'b1;
         end
         if (ld_out) begin
            r_p   <= w_prod[FRAC+WIDTH-1:FRAC];
            r_ovf <= |w_prod[2*WIDTH-1:FRAC+WIDTH];
         end
      end
   end

   assign p_out = r_p;
   assign ovf   = r_ovf;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned fixed-point multiplier, one multiplier bit per cycle,
// with a start/busy/valid handshake shared with the divider.
//   clk, sclr_n  : clock, synchronous active-low reset
//   start        : request, sampled when not busy (IDLE or DONE)
//   a_in, b_in   : multiplicand, multiplier (captured on accepted start)
//   busy         : operation in progress (WIDTH cycles)
//   valid        : one-cycle pulse, new p_out/ovf
//   ovf          : product did not fit in WIDTH bits
//   p_out        : product in the operand Q-format, held until next result
module shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned FRAC  = DEF_FRAC
) (
   input  logic             clk,
   input  logic             sclr_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             valid,
   output logic             ovf,
   output logic [WIDTH-1:0] p_out
);

   state_t r_state;
   logic   r_busy;
   logic   r_valid;

   logic   w_ld;
   logic   w_shen;
   logic   w_ld_out;
   logic   w_cnt_done;

   // DONE accepts a start exactly like IDLE, giving back-to-back operation.
   assign w_ld     = (r_state != ST_RUN) && start;
   assign w_shen   = (r_state == ST_RUN);
   assign w_ld_out = w_shen && w_cnt_done;

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_cnt_done) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            default: begin
               r_valid <= 1'b0;
               if (start) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   shift_add_datapath #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_dp (
      .clk      (clk),
      .sclr_n   (sclr_n),
      .ld       (w_ld),
      .shen     (w_shen),
      .ld_out   (w_ld_out),
      .a_in     (a_in),
      .b_in     (b_in),
      .cnt_done (w_cnt_done),
      .p_out    (p_out),
      .ovf      (ovf)
   );

   assign busy  = r_busy;
   assign valid = r_valid;

endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;

   localparam int unsigned W = 10;

   logic         clk = 1'b0;
   logic         sclr_n = 1'b0;

   logic         s0_start = 1'b0;
   logic [W-1:0] s0_a = '0, s0_b = '0;
   logic         s0_busy, s0_valid, s0_ovf;
   logic [W-1:0] s0_p;

   logic         s4_start = 1'b0;
   logic [W-1:0] s4_a = '0, s4_b = '0;
   logic         s4_busy, s4_valid, s4_ovf;
   logic [W-1:0] s4_p;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.WIDTH(W), .FRAC(0)) u0 (
      .clk(clk), .sclr_n(sclr_n), .start(s0_start), .a_in(s0_a), .b_in(s0_b),
      .busy(s0_busy), .valid(s0_valid), .ovf(s0_ovf), .p_out(s0_p));

   shift_add_multiplier #(.WIDTH(W), .FRAC(4)) u4 (
      .clk(clk), .sclr_n(sclr_n), .start(s4_start), .a_in(s4_a), .b_in(s4_b),
      .busy(s4_busy), .valid(s4_valid), .ovf(s4_ovf), .p_out(s4_p));

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] p;
      logic         ovf;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: full-precision product, then drop FRAC bits and split at W.
   task automatic model(input int unsigned a, input int unsigned b, input int unsigned frac,
                        output int unsigned p, output bit ovf);
      longint unsigned prod;
      prod = longint'(a) * longint'(b);
      p    = int'((prod >> frac) % (64'd1 << W));
      ovf  = ((prod >> (frac + W)) != 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the FRAC=0 unit, checking latency and the pulse.
   task automatic op0(input string name, input int unsigned a, input int unsigned b,
                      input int unsigned ep, input bit eovf);
      int k = 0;
      int bc = 0;
      s0_a = W'(a); s0_b = W'(b); s0_start = 1'b1;
      tick();
      s0_start = 1'b0;
      s0_a = '0; s0_b = '0;
      while (!s0_valid && k < 40) begin
         if (s0_busy) bc++;
         tick();
         k++;
      end
      chk({name, " valid"}, s0_valid, 1);
      chk({name, " latency"}, k, W);
      chk({name, " busy_cycles"}, bc, W);
      chk({name, " p_out"}, s0_p, ep);
      chk({name, " ovf"}, s0_ovf, eovf);
      tick();
      chk({name, " valid_pulse_end"}, s0_valid, 0);
      chk({name, " p_out_held"}, s0_p, ep);
   endtask

   task automatic op4(input string name, input int unsigned a, input int unsigned b,
                      input int unsigned ep, input bit eovf);
      int k = 0;
      s4_a = W'(a); s4_b = W'(b); s4_start = 1'b1;
      tick();
      s4_start = 1'b0;
      while (!s4_valid && k < 40) begin
         tick();
         k++;
      end
      chk({name, " latency"}, k, W);
      chk({name, " p_out"}, s4_p, ep);
      chk({name, " ovf"}, s4_ovf, eovf);
   endtask

   initial begin
      int unsigned mp;
      bit          mo;
      int          k;
      int          unstable;
      bit          seen;

      tbl[0] = '{a: 10'd25,   b: 10'd20,   p: 10'd500, ovf: 1'b0};
      tbl[1] = '{a: 10'd40,   b: 10'd30,   p: 10'd176, ovf: 1'b1};
      tbl[2] = '{a: 10'd1023, b: 10'd1023, p: 10'd1,   ovf: 1'b1};
      tbl[3] = '{a: 10'd0,    b: 10'd1023, p: 10'd0,   ovf: 1'b0};
      tbl[4] = '{a: 10'd1,    b: 10'd513,  p: 10'd513, ovf: 1'b0};
      tbl[5] = '{a: 10'd7,    b: 10'd9,    p: 10'd63,  ovf: 1'b0};

      // Reset state
      tick(); tick();
      sclr_n = 1'b1;
      tick();
      chk("reset busy", s0_busy, 0);
      chk("reset valid", s0_valid, 0);
      chk("reset ovf", s0_ovf, 0);
      chk("reset p_out", s0_p, 0);

      // Table vectors
      for (int i = 0; i < 6; i++)
         op0($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].ovf);

      // Reset mid-RUN after an overflowing result so clearing is visible
      op0("pre_reset", 40, 30, 176, 1'b1);
      s0_a = 10'd7; s0_b = 10'd9; s0_start = 1'b1;
      tick();
      s0_start = 1'b0;
      tick(); tick(); tick();
      sclr_n = 1'b0;
      tick();
      sclr_n = 1'b1;
      chk("midrst busy", s0_busy, 0);
      chk("midrst valid", s0_valid, 0);
      chk("midrst ovf", s0_ovf, 0);
      chk("midrst p_out", s0_p, 0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (s0_valid || s0_busy) seen = 1'b1;
         tick();
      end
      chk("midrst no_activity", seen, 0);
      op0("post_reset", 7, 9, 63, 1'b0);

      // start during RUN is ignored and not queued
      s0_a = 10'd25; s0_b = 10'd20; s0_start = 1'b1;
      tick();
      s0_start = 1'b0;
      tick(); tick();
      s0_a = 10'd3; s0_b = 10'd3; s0_start = 1'b1;
      tick();
      s0_start = 1'b0;
      k = 0;
      while (!s0_valid && k < 40) begin tick(); k++; end
      chk("ignore valid", s0_valid, 1);
      chk("ignore p_out", s0_p, 500);
      tick();
      chk("ignore not_queued", s0_busy, 0);

      // start held high: back-to-back operations
      s0_a = 10'd3; s0_b = 10'd5; s0_start = 1'b1;
      tick();
      k = 0;
      while (!s0_valid && k < 40) begin tick(); k++; end
      chk("b2b first valid", s0_valid, 1);
      chk("b2b first p_out", s0_p, 15);
      s0_a = 10'd6; s0_b = 10'd7;
      tick();
      k = 1;
      unstable = 0;
      while (!s0_valid && k < 40) begin
         if (s0_p != 10'd15) unstable++;
         tick();
         k++;
      end
      s0_start = 1'b0;
      chk("b2b spacing", k, W + 1);
      chk("b2b p_out_stable", unstable, 0);
      chk("b2b second p_out", s0_p, 42);
      chk("b2b second ovf", s0_ovf, 0);
      tick(); tick();

      // Fixed point, FRAC=4
      op4("q4 2.5x1.5", 10'h028, 10'h018, 10'h03C, 1'b0);
      op4("q4 ovf", 10'h3FF, 10'h020, 10'd1022, 1'b1);

      // Randomized against the reference model
      for (int i = 0; i < 20; i++) begin
         int unsigned a, b;
         a = $urandom_range(0, 1023);
         b = $urandom_range(0, 1023);
         model(a, b, 0, mp, mo);
         op0($sformatf("rnd%0d %0dx%0d", i, a, b), a, b, mp, mo);
      end
      for (int i = 0; i < 8; i++) begin
         int unsigned a, b;
         a = $urandom_range(0, 1023);
         b = $urandom_range(0, 1023);
         model(a, b, 4, mp, mo);
         op4($sformatf("rnd4_%0d %0dx%0d", i, a, b), a, b, mp, mo);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
